branch_recovery: RTL and testbench

Consumes the branch unit's resolved `b_data` result and turns it into machine-wide recovery actions. A taken BNE (mispredict) or a JALR target triggers a fetch redirect; a mispredict additionally flushes younger state and walks the ROB backward from tail to the branch, restoring the rename map and returning physical registers to the free list one entry per cycle. Sits between the branch FU output and the fetch, rename, free-list and ROB blocks.

---
 rtl/branch_recovery_pkg.sv | 30 +++
 rtl/branch_recovery.sv | 191 +++++++++++++++++++
 tb/tb_branch_recovery.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_recovery_pkg.sv
// Shared types for branch misprediction recovery: branch FU result record,
// recovery FSM states and ROB tag arithmetic (tags wrap modulo ROB_DEPTH).
package branch_recovery_pkg;
  localparam int ROB_DEPTH = 16;
  localparam int TAG_W     = 5;

  typedef enum logic [1:0] {IDLE, FLUSH, WALK, DONE} recov_state_t;

  typedef struct packed {
    logic             fu_b_done;
    logic             mispredict;
    logic [TAG_W-1:0] mispredict_tag;
    logic             jalr_bne_signal;
    logic [31:0]      pc;
  } b_data;

  function automatic logic [TAG_W-1:0] tag_next(input logic [TAG_W-1:0] t);
    return (t == TAG_W'(ROB_DEPTH - 1)) ? '0 : t + 1'b1;
  endfunction

  function automatic logic [TAG_W-1:0] tag_prev(input logic [TAG_W-1:0] t);
    return (t == '0) ? TAG_W'(ROB_DEPTH - 1) : t - 1'b1;
  endfunction

  // Distance from the ROB head; a smaller age means an older instruction.
  function automatic logic [TAG_W-1:0] rob_age(input logic [TAG_W-1:0] t,
                                               input logic [TAG_W-1:0] head);
    return (t >= head) ? t - head : t + TAG_W'(ROB_DEPTH) - head;
  endfunction
endpackage

// File: rtl/branch_recovery.sv
// Branch recovery: turns resolved branches into redirect/flush pulses and walks
// the ROB backward restoring rename mappings. BR_RECOVERY_STATS_EN adds counters.
module branch_recovery
  import branch_recovery_pkg::*;
#(
  parameter int PREG_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  b_data             br_in,
  input  logic [4:0]        rob_head,
  input  logic [4:0]        rob_tail,
  output logic [4:0]        rob_rd_idx,
  input  logic              rob_rd_regwrite,
  input  logic [4:0]        rob_rd_rd,
  input  logic [PREG_W-1:0] rob_rd_pd,
  input  logic [PREG_W-1:0] rob_rd_old_pd,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic              flush,
  output logic [4:0]        flush_tag,
  output logic              restore_valid,
  output logic [4:0]        restore_rd,
  output logic [PREG_W-1:0] restore_old_pd,
  output logic              free_valid,
  output logic [PREG_W-1:0] free_pd,
  output logic              tail_set_valid,
  output logic [4:0]        tail_set,
  output logic              busy
`ifdef BR_RECOVERY_STATS_EN
  ,
  output logic [31:0]       mispredict_count,
  output logic [31:0]       recovery_cycles
`endif
);

  recov_state_t      r_state;
  logic              r_busy;
  logic [4:0]        r_stop;
  logic [4:0]        r_idx;
  logic              r_from_tail;
  logic              r_redirect_valid;
  logic [31:0]       r_redirect_pc;
  logic              r_flush;
  logic [4:0]        r_flush_tag;
  logic [4:0]        r_rob_rd_idx;
  logic              r_restore_valid;
  logic [4:0]        r_restore_rd;
  logic [PREG_W-1:0] r_restore_old_pd;
  logic              r_free_valid;
  logic [PREG_W-1:0] r_free_pd;
  logic              r_tail_set_valid;
  logic [4:0]        r_tail_set;

  logic              w_new_mp;
  logic              w_older;
  logic              w_accept;
  logic [4:0]        w_walk_start;
  logic              w_flush_done;

  assign w_new_mp     = br_in.fu_b_done && br_in.mispredict;
  assign w_older      = rob_age(br_in.mispredict_tag, rob_head) < rob_age(r_stop, rob_head);
  assign w_accept     = w_new_mp && ((r_state == IDLE) || w_older);
  // r_idx is the next entry still to be undone; a fresh recovery starts at tail-1.
  assign w_walk_start = r_from_tail ? tag_prev(rob_tail) : r_idx;
  assign w_flush_done = r_from_tail ? (tag_next(r_stop) == rob_tail)
                                    : (rob_age(r_idx, rob_head) <= rob_age(r_stop, rob_head));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= IDLE;
      r_busy           <= 1'b0;
      r_stop           <= '0;
      r_idx            <= '0;
      r_from_tail      <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_flush          <= 1'b0;
      r_flush_tag      <= '0;
      r_rob_rd_idx     <= '0;
      r_restore_valid  <= 1'b0;
      r_restore_rd     <= '0;
      r_restore_old_pd <= '0;
      r_free_valid     <= 1'b0;
      r_free_pd        <= '0;
      r_tail_set_valid <= 1'b0;
      r_tail_set       <= '0;
    end else begin
      r_redirect_valid <= 1'b0;
      r_flush          <= 1'b0;
      r_restore_valid  <= 1'b0;
      r_free_valid     <= 1'b0;
      r_tail_set_valid <= 1'b0;
      if (w_accept) begin
        // Retarget aborts the entry being read this cycle; it is re-walked later.
        r_state          <= FLUSH;
        r_busy           <= 1'b1;
        r_stop           <= br_in.mispredict_tag;
        r_redirect_valid <= 1'b1;
        r_redirect_pc    <= br_in.pc;
        r_flush          <= 1'b1;
        r_flush_tag      <= br_in.mispredict_tag;
        if (r_state == IDLE) begin
          r_from_tail <= 1'b1;
        end else if (r_state != FLUSH) begin
          r_from_tail <= 1'b0;
        end
      end else begin
        case (r_state)
          IDLE: begin
            if (br_in.fu_b_done && !br_in.mispredict && br_in.jalr_bne_signal) begin
              r_redirect_valid <= 1'b1;
              r_redirect_pc    <= br_in.pc;
            end
          end
          FLUSH: begin
            r_from_tail <= 1'b0;
            r_idx       <= w_walk_start;
            if (w_flush_done) begin
              r_state          <= DONE;
              r_tail_set_valid <= 1'b1;
              r_tail_set       <= tag_next(r_stop);
            end else begin
              r_state      <= WALK;
              r_rob_rd_idx <= w_walk_start;
            end
          end
          WALK: begin
            if (rob_rd_regwrite && (rob_rd_rd != '0)) begin
              r_restore_valid  <= 1'b1;
              r_restore_rd     <= rob_rd_rd;
              r_restore_old_pd <= rob_rd_old_pd;
              r_free_valid     <= 1'b1;
              r_free_pd        <= rob_rd_pd;
            end
            r_idx <= tag_prev(r_idx);
            if (r_idx == tag_next(r_stop)) begin
              r_state          <= DONE;
              r_tail_set_valid <= 1'b1;
              r_tail_set       <= tag_next(r_stop);
            end else begin
              r_rob_rd_idx <= tag_prev(r_idx);
            end
          end
          DONE: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign rob_rd_idx     = r_rob_rd_idx;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign flush          = r_flush;
  assign flush_tag      = r_flush_tag;
  assign restore_valid  = r_restore_valid;
  assign restore_rd     = r_restore_rd;
  assign restore_old_pd = r_restore_old_pd;
  assign free_valid     = r_free_valid;
  assign free_pd        = r_free_pd;
  assign tail_set_valid = r_tail_set_valid;
  assign tail_set       = r_tail_set;
  assign busy           = r_busy;

`ifdef BR_RECOVERY_STATS_EN
  logic [31:0] r_mispredict_count;
  logic [31:0] r_recovery_cycles;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mispredict_count <= '0;
      r_recovery_cycles  <= '0;
    end else begin
      if (w_accept && (r_mispredict_count != '1)) begin
        r_mispredict_count <= r_mispredict_count + 1'b1;
      end
      if (r_busy && (r_recovery_cycles != '1)) begin
        r_recovery_cycles <= r_recovery_cycles + 1'b1;
      end
    end
  end

  assign mispredict_count = r_mispredict_count;
  assign recovery_cycles  = r_recovery_cycles;
`endif

endmodule

// File: tb/tb_branch_recovery.sv
// Self-checking bench for branch_recovery: directed and random recoveries
// compared against an event-level model of redirect/flush/walk/restore.
module tb_branch_recovery;
  import branch_recovery_pkg::*;

  localparam int PREG_W   = 7;
  localparam int MAX_WAIT = 100;

  logic              clk = 1'b0;
  logic              reset;
  b_data             br_in;
  logic [4:0]        rob_head;
  logic [4:0]        rob_tail;
  logic [4:0]        rob_rd_idx;
  logic              rob_rd_regwrite;
  logic [4:0]        rob_rd_rd;
  logic [PREG_W-1:0] rob_rd_pd;
  logic [PREG_W-1:0] rob_rd_old_pd;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              flush;
  logic [4:0]        flush_tag;
  logic              restore_valid;
  logic [4:0]        restore_rd;
  logic [PREG_W-1:0] restore_old_pd;
  logic              free_valid;
  logic [PREG_W-1:0] free_pd;
  logic              tail_set_valid;
  logic [4:0]        tail_set;
  logic              busy;
`ifdef BR_RECOVERY_STATS_EN
  logic [31:0]       mispredict_count;
  logic [31:0]       recovery_cycles;
`endif

  always #5 clk = ~clk;

  branch_recovery #(.PREG_W(PREG_W)) dut (
    .clk(clk), .reset(reset), .br_in(br_in),
    .rob_head(rob_head), .rob_tail(rob_tail), .rob_rd_idx(rob_rd_idx),
    .rob_rd_regwrite(rob_rd_regwrite), .rob_rd_rd(rob_rd_rd),
    .rob_rd_pd(rob_rd_pd), .rob_rd_old_pd(rob_rd_old_pd),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .flush_tag(flush_tag),
    .restore_valid(restore_valid), .restore_rd(restore_rd), .restore_old_pd(restore_old_pd),
    .free_valid(free_valid), .free_pd(free_pd),
    .tail_set_valid(tail_set_valid), .tail_set(tail_set), .busy(busy)
`ifdef BR_RECOVERY_STATS_EN
    , .mispredict_count(mispredict_count), .recovery_cycles(recovery_cycles)
`endif
  );

  // ROB contents seen by the combinational read port
  logic              rob_rw  [16];
  logic [4:0]        rob_rdn [16];
  logic [PREG_W-1:0] rob_pd  [16];
  logic [PREG_W-1:0] rob_opd [16];

  assign rob_rd_regwrite = rob_rw[rob_rd_idx[3:0]];
  assign rob_rd_rd       = rob_rdn[rob_rd_idx[3:0]];
  assign rob_rd_pd       = rob_pd[rob_rd_idx[3:0]];
  assign rob_rd_old_pd   = rob_opd[rob_rd_idx[3:0]];

  int n_checks = 0;
  int n_pass   = 0;

  // Event log captured on the falling edge
  int cyc = 0, busy_cycles = 0, flush_cyc = 0, tail_cyc = 0;
  int q_redir[$], q_flush[$], q_walk[$], q_rest[$], q_free[$], q_tail[$];

  always @(negedge clk) begin
    cyc++;
    if (busy) busy_cycles++;
    if (redirect_valid) q_redir.push_back(int'(redirect_pc));
    if (flush) begin
      q_flush.push_back(int'(flush_tag));
      flush_cyc = cyc;
    end
    if (busy && !flush && !tail_set_valid) q_walk.push_back(int'(rob_rd_idx));
    if (restore_valid) q_rest.push_back(int'(restore_rd) * 256 + int'(restore_old_pd));
    if (free_valid) q_free.push_back(int'(free_pd));
    if (tail_set_valid) begin
      q_tail.push_back(int'(tail_set));
      tail_cyc = cyc;
    end
  end

  task automatic clear_log();
    q_redir.delete(); q_flush.delete(); q_walk.delete();
    q_rest.delete();  q_free.delete();  q_tail.delete();
    busy_cycles = 0;
  endtask

  function automatic bit same_q(input int a[$], input int b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] != b[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic string q2s(input int a[$]);
    string s = "[";
    foreach (a[i]) s = {s, $sformatf(" %0d", a[i])};
    return {s, " ]"};
  endfunction

  task automatic fill_rob();
    for (int i = 0; i < 16; i++) begin
      rob_rw[i]  = ($urandom_range(0, 3) != 0);
      rob_rdn[i] = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rob_pd[i]  = PREG_W'($urandom_range(0, 127));
      rob_opd[i] = PREG_W'($urandom_range(0, 127));
    end
  endtask

  // Reference: entries undone by a walk from 'start' down to stop+1, in order
  task automatic model_walk(input int start, input int stop,
                            inout int walk[$], inout int rest[$], inout int fre[$]);
    int n = (start - stop + 32) % 16;
    for (int k = 0; k < n; k++) begin
      int idx = (start - k + 32) % 16;
      walk.push_back(idx);
      if (rob_rw[idx] && rob_rdn[idx] != 0) begin
        rest.push_back(int'(rob_rdn[idx]) * 256 + int'(rob_opd[idx]));
        fre.push_back(int'(rob_pd[idx]));
      end
    end
  endtask

  // Caller must be at a falling edge; the branch is sampled on the next rising edge.
  task automatic send_br(input bit mp, input bit jalr, input int tag, input logic [31:0] pc);
    br_in.fu_b_done       = 1'b1;
    br_in.mispredict      = mp;
    br_in.jalr_bne_signal = jalr;
    br_in.mispredict_tag  = 5'(tag);
    br_in.pc              = pc;
    @(negedge clk);
    br_in = '0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < MAX_WAIT && !ok; i++) begin
      if (!busy) ok = 1'b1;
      else @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_walk_idx(input int idx, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < MAX_WAIT && !ok; i++) begin
      if (busy && !flush && !tail_set_valid && int'(rob_rd_idx) == idx) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; br_in = '0; rob_head = '0; rob_tail = '0;
    fill_rob();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({redirect_valid, flush, restore_valid, free_valid, tail_set_valid, busy} !== 6'b0)
      $display("FAIL reset_pulses: got %b required 000000",
               {redirect_valid, flush, restore_valid, free_valid, tail_set_valid, busy});
    else n_pass++;
    n_checks++;
    if ({redirect_pc, flush_tag, rob_rd_idx, tail_set, restore_rd} !== 52'b0)
      $display("FAIL reset_data: pc=%h flush_tag=%0d rd_idx=%0d tail_set=%0d required 0",
               redirect_pc, flush_tag, rob_rd_idx, tail_set);
    else n_pass++;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_release_busy: got %b required 0", busy);
    else n_pass++;
    $display("reset: busy=%b", busy);
  endtask

  task automatic test_jalr();
    bit ok;
    clear_log();
    send_br(1'b0, 1'b1, 0, 32'h100);
    wait_idle(ok);
    repeat (2) @(negedge clk);
    n_checks++;
    if (q_redir.size() != 1 || q_redir[0] != 32'h100)
      $display("FAIL jalr_redirect: got %s required [ 256 ]", q2s(q_redir));
    else n_pass++;
    n_checks++;
    if (q_flush.size() != 0 || busy_cycles != 0 || q_tail.size() != 0)
      $display("FAIL jalr_no_recovery: flushes=%0d busy_cycles=%0d tail_sets=%0d required 0 0 0",
               q_flush.size(), busy_cycles, q_tail.size());
    else n_pass++;
    $display("jalr pc=0x100 redirects=%0d", q_redir.size());
    clear_log();
    send_br(1'b0, 1'b0, 4, 32'h444);
    repeat (4) @(negedge clk);
    n_checks++;
    if (q_redir.size() != 0 || q_flush.size() != 0 || busy_cycles != 0)
      $display("FAIL plain_branch_quiet: redirects=%0d flushes=%0d busy=%0d required 0 0 0",
               q_redir.size(), q_flush.size(), busy_cycles);
    else n_pass++;
    $display("correct branch: redirects=%0d", q_redir.size());
  endtask

  task automatic test_mispredict(input int head, input int stop, input int tail, input logic [31:0] pc);
    int exp_walk[$], exp_rest[$], exp_free[$], exp_redir[$], exp_flush[$], exp_tail[$];
    int n;
    bit ok;
    fill_rob();
    rob_head = 5'(head);
    rob_tail = 5'(tail);
    model_walk((tail - 1 + 16) % 16, stop, exp_walk, exp_rest, exp_free);
    n = exp_walk.size();
    exp_redir.push_back(int'(pc));
    exp_flush.push_back(stop);
    exp_tail.push_back((stop + 1) % 16);
    clear_log();
    send_br(1'b1, 1'b0, stop, pc);
    wait_idle(ok);
    n_checks++;
    if (!ok) $display("FAIL mp_timeout: busy still %b after %0d cycles required 0", busy, MAX_WAIT);
    else n_pass++;
    n_checks++;
    if (!same_q(q_redir, exp_redir)) $display("FAIL mp_redirect: got %s required %s", q2s(q_redir), q2s(exp_redir));
    else n_pass++;
    n_checks++;
    if (!same_q(q_flush, exp_flush)) $display("FAIL mp_flush_tag: got %s required %s", q2s(q_flush), q2s(exp_flush));
    else n_pass++;
    n_checks++;
    if (!same_q(q_walk, exp_walk)) $display("FAIL mp_walk_idx: got %s required %s", q2s(q_walk), q2s(exp_walk));
    else n_pass++;
    n_checks++;
    if (!same_q(q_rest, exp_rest)) $display("FAIL mp_restore: got %s required %s", q2s(q_rest), q2s(exp_rest));
    else n_pass++;
    n_checks++;
    if (!same_q(q_free, exp_free)) $display("FAIL mp_free: got %s required %s", q2s(q_free), q2s(exp_free));
    else n_pass++;
    n_checks++;
    if (!same_q(q_tail, exp_tail)) $display("FAIL mp_tail_set: got %s required %s", q2s(q_tail), q2s(exp_tail));
    else n_pass++;
    n_checks++;
    if (busy_cycles != n + 2) $display("FAIL mp_busy_cycles: got %0d required %0d", busy_cycles, n + 2);
    else n_pass++;
    n_checks++;
    if (tail_cyc - flush_cyc != n + 1)
      $display("FAIL mp_tail_latency: got %0d required %0d", tail_cyc - flush_cyc, n + 1);
    else n_pass++;
    $display("mispredict head=%0d stop=%0d tail=%0d pc=%h walked=%0d restores=%0d",
             head, stop, tail, pc, q_walk.size(), q_rest.size());
  endtask

  task automatic test_retarget();
    int exp_walk[$], exp_rest[$], exp_free[$], exp_redir[$], exp_flush[$], exp_tail[$];
    bit ok1, ok2, ok3;
    fill_rob();
    rob_head = 5'd0;
    rob_tail = 5'd12;
    // Entry 11 undone, entry 10 read when the older branch arrives, then 10..3
    model_walk(11, 10, exp_walk, exp_rest, exp_free);
    exp_walk.push_back(10);
    model_walk(10, 2, exp_walk, exp_rest, exp_free);
    exp_redir.push_back(32'h800); exp_redir.push_back(32'h200);
    exp_flush.push_back(8);       exp_flush.push_back(2);
    exp_tail.push_back(3);
    clear_log();
    send_br(1'b1, 1'b0, 8, 32'h800);
    wait_walk_idx(10, ok1);
    send_br(1'b1, 1'b0, 2, 32'h200);
    wait_walk_idx(6, ok2);
    send_br(1'b1, 1'b0, 9, 32'h900);
    wait_idle(ok3);
    n_checks++;
    if (!(ok1 && ok2 && ok3)) $display("FAIL rt_timeout: reached=%b%b%b required 111", ok1, ok2, ok3);
    else n_pass++;
    n_checks++;
    if (!same_q(q_redir, exp_redir)) $display("FAIL rt_redirect: got %s required %s", q2s(q_redir), q2s(exp_redir));
    else n_pass++;
    n_checks++;
    if (!same_q(q_flush, exp_flush)) $display("FAIL rt_flush_tag: got %s required %s", q2s(q_flush), q2s(exp_flush));
    else n_pass++;
    n_checks++;
    if (!same_q(q_walk, exp_walk)) $display("FAIL rt_walk_idx: got %s required %s", q2s(q_walk), q2s(exp_walk));
    else n_pass++;
    n_checks++;
    if (!same_q(q_rest, exp_rest)) $display("FAIL rt_restore: got %s required %s", q2s(q_rest), q2s(exp_rest));
    else n_pass++;
    n_checks++;
    if (!same_q(q_free, exp_free)) $display("FAIL rt_free: got %s required %s", q2s(q_free), q2s(exp_free));
    else n_pass++;
    n_checks++;
    if (!same_q(q_tail, exp_tail)) $display("FAIL rt_tail_set: got %s required %s", q2s(q_tail), q2s(exp_tail));
    else n_pass++;
    n_checks++;
    if (busy_cycles != 3 + 8 + 2) $display("FAIL rt_busy_cycles: got %0d required %0d", busy_cycles, 13);
    else n_pass++;
    $display("retarget stop 8->2 then tag 9 ignored: flushes=%0d tail_set=%s", q_flush.size(), q2s(q_tail));
  endtask

  task automatic test_jalr_busy();
    bit ok1, ok2;
    fill_rob();
    rob_head = 5'd0;
    rob_tail = 5'd7;
    clear_log();
    send_br(1'b1, 1'b0, 3, 32'h80);
    wait_walk_idx(5, ok1);
    send_br(1'b0, 1'b1, 0, 32'h200);
    wait_idle(ok2);
    n_checks++;
    if (!(ok1 && ok2) || q_redir.size() != 1 || q_redir[0] != 32'h80)
      $display("FAIL jalr_busy_redirect: got %s required [ 128 ]", q2s(q_redir));
    else n_pass++;
    n_checks++;
    if (q_tail.size() != 1 || q_tail[0] != 4)
      $display("FAIL jalr_busy_tail_set: got %s required [ 4 ]", q2s(q_tail));
    else n_pass++;
    $display("jalr while busy: redirects=%0d", q_redir.size());
  endtask

  task automatic test_reset_mid_walk();
    bit ok;
    fill_rob();
    rob_head = 5'd0;
    rob_tail = 5'd15;
    clear_log();
    send_br(1'b1, 1'b0, 0, 32'hABC);
    wait_walk_idx(10, ok);
    reset = 1'b0;
    #1;
    n_checks++;
    if (!ok || {redirect_valid, flush, restore_valid, free_valid, tail_set_valid, busy} !== 6'b0)
      $display("FAIL midwalk_reset_pulses: reached=%b got %b required 000000", ok,
               {redirect_valid, flush, restore_valid, free_valid, tail_set_valid, busy});
    else n_pass++;
    n_checks++;
    if ({redirect_pc, flush_tag, rob_rd_idx, tail_set, restore_rd, free_pd} !== 59'b0)
      $display("FAIL midwalk_reset_data: pc=%h flush_tag=%0d rd_idx=%0d required 0",
               redirect_pc, flush_tag, rob_rd_idx);
    else n_pass++;
    clear_log();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (busy_cycles != 0 || q_rest.size() != 0 || q_tail.size() != 0)
      $display("FAIL midwalk_after_reset: busy=%0d restores=%0d tail_sets=%0d required 0 0 0",
               busy_cycles, q_rest.size(), q_tail.size());
    else n_pass++;
    $display("reset mid-walk: busy=%b", busy);
  endtask

  initial begin
    test_reset();
    test_jalr();
    test_mispredict(0, 3, 7, 32'h80);
    test_mispredict(0, 14, 2, 32'h1234);
    test_mispredict(0, 5, 6, 32'h5678);
    for (int i = 0; i < 20; i++) begin
      test_mispredict($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                      $urandom());
    end
    test_retarget();
    test_jalr_busy();
    test_reset_mid_walk();
    test_mispredict(0, 9, 13, 32'hBEEF);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
